// File: rtl/lfsr_gen.sv
// Parametrised LFSR with Fibonacci or Galois structure, runtime seed load,
// all-zero lockup recovery and a period counter that pulses on each wrap.
module lfsr_gen #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int unsigned      MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] Qout,
  output logic             bit_out,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             lockup_q, lockup_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] next_s;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    if (MODE == 32'd0) begin
      r = {s[WIDTH-2:0], ^(s & TAPS)};
    end else begin
      r = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : ZERO);
    end
    return r;
  endfunction

  assign next_s = lfsr_next(q_q);

  // Priority: load > zero-state recovery > step > hold; pulses default low.
  always_comb begin
    q_d      = q_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    lockup_d = 1'b0;
    wrap_d   = 1'b0;
    if (load) begin
      q_d     = seed_in;
      start_d = seed_in;
      cnt_d   = ZERO;
    end else if (en && (q_q == ZERO)) begin
      q_d      = SEED;
      start_d  = SEED;
      cnt_d    = ZERO;
      lockup_d = 1'b1;
    end else if (en) begin
      q_d = next_s;
      if (next_s == start_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_q + ONE;
        cnt_d    = ZERO;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      q_d = q_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q      <= SEED;
      start_q  <= SEED;
      cnt_q    <= ZERO;
      period_q <= ZERO;
      lockup_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      lockup_q <= lockup_d;
      wrap_q   <= wrap_d;
    end
  end

  assign Qout    = q_q;
  assign bit_out = q_q[WIDTH-1];
  assign lockup  = lockup_q;
  assign wrap    = wrap_q;
  assign period  = period_q;

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised successor to the fixed 3-bit LFSR: configurable width, tap polynomial and seed, with Fibonacci or Galois structure.
- Adds step enable, runtime seed load, all-zero lockup recovery and a period counter with a wrap pulse.
- Used as a pseudo-random stimulus/scrambler source; a drop-in for the old LFSR when WIDTH=3, TAPS=3'b110, SEED=3'b001, MODE=0.

Parameters:
- WIDTH, 8, register width (2..32).
- TAPS, 8'hB8, tap mask. MODE=0: bit i set means Qout[i] feeds the XOR. MODE=1: Galois XOR mask; bit 0 must be 1.
- SEED, 8'h01, reset/recovery state; must be non-zero.
- MODE, 0, 0 = Fibonacci, 1 = Galois.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  advance one step this cycle.
- load  in  1  load seed_in this cycle; has priority over en.
- seed_in  in  WIDTH  runtime seed value.
- Qout  out  WIDTH  current LFSR state.
- bit_out  out  1  serial output, equal to Qout[WIDTH-1] (combinational from Qout).
- lockup  out  1  one-cycle pulse when a zero state is replaced by SEED.
- wrap  out  1  one-cycle pulse when the sequence returns to its start state.
- period  out  WIDTH  step count of the last completed cycle.

Behaviour:
- Reset (rst=0 at a clock edge): Qout=SEED, lockup=0, wrap=0, period=0. Internal step counter cnt=0; internal start register ref=SEED. Reset overrides load and en, and may be applied at any cycle.
- Next-state function, Fibonacci (MODE=0): fb = XOR of Qout[i] over all i with TAPS[i]=1; next = {Qout[WIDTH-2:0], fb}.
- Next-state function, Galois (MODE=1): next = {Qout[WIDTH-2:0], 1'b0} XOR (Qout[WIDTH-1] ? TAPS : 0).
- Priority per cycle: reset > load > lockup recovery > step > hold.
- load=1: Qout=seed_in, ref=seed_in, cnt=0, no step taken. If en=1 in the same cycle it is ignored.
- Lockup recovery: condition is en=1, load=0, Qout==0. Action: Qout=SEED, ref=SEED, cnt=0, lockup=1 for one cycle; wrap is not asserted.
- Step: condition is en=1, load=0, Qout!=0. Action: Qout=next.
  - If next==ref: wrap=1 for one cycle, period=cnt+1 (truncated to WIDTH bits), cnt=0.
  - Otherwise: cnt=cnt+1, with natural wrap-around at 2^WIDTH.
- en=0 and load=0: all state holds; lockup and wrap drop to 0 on the next edge, because they are pulses only.
- Latency: Qout reflects load/step one cycle after the control is sampled. wrap and period update on the same edge as the Qout that equals ref.
- period holds its value until the next wrap or reset; load does not clear it.
- A non-maximal TAPS gives a shorter cycle; period reports the true cycle length.
- A sequence that never revisits ref (ref off-cycle) never raises wrap.

Test Plan:
- WIDTH=3, TAPS=3'b110, SEED=3'b001, MODE=0; release reset, hold en=1 -> Qout = 001,010,101,011,111,110,100,001. wrap=1 on the cycle Qout returns to 001; period=7.
- Same sequence, but de-assert en for 3 cycles after Qout=101 -> Qout holds 101 with no wrap. Resuming gives 011 next; total wrap still at 7 steps, period=7.
- MODE=1, TAPS=3'b011, SEED=3'b001, en=1 -> Qout = 001,010,100,011,110,111,101,001. wrap pulses once; period=7.
- load=1 with seed_in=3'b000 and en=1 in the same cycle -> Qout=000 (load wins). Next cycle with en=1 -> Qout=001 and lockup=1 for exactly one cycle; wrap=0.
- Mid-sequence load seed_in=3'b111, then en=1 -> 110,100,001,010,101,011,111. wrap on the return to 111; period=7.
- rst=0 asserted while en=1 at Qout=011 -> next edge Qout=001, period=0, wrap=0. Asynchronous pulses on rst that do not span a rising edge have no effect.
